// File: rtl/led_blink_sched.sv
// led_blink_sched: three-requester priority LED blink scheduler.
// A granted requester blinks the LED at its latched rate and keeps the grant
// for at least MIN_PERIODS full blink periods before release or re-arbitration.
// Optional feature macro: LED_BLINK_SCHED_PREEMPT_EN (a higher-priority request
// preempts immediately instead of waiting for the hold to complete).
module led_blink_sched #(
  parameter int PRESCALE    = 1000,
  parameter int HALF0       = 1,
  parameter int HALF1       = 5,
  parameter int HALF2       = 10,
  parameter int HALF3       = 100,
  parameter int MIN_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] req,
  input  logic [5:0] rate,
  output logic [2:0] grant,
  output logic [1:0] cur_rate,
  output logic       led,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  ph_cnt_q, ph_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  per_q, per_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  cur_rate_q, cur_rate_d;
  logic        led_q, led_d;
  logic        busy_q, busy_d;

  logic        tick, hold_done, higher, owner_low, do_grant, go_idle;
  logic [7:0]  half_sel;
  logic [2:0]  top_oh;
  logic [1:0]  top_rate;

  assign tick      = en && (pre_q == 16'(PRESCALE - 1));
  assign hold_done = (per_q == 4'(MIN_PERIODS));
  assign owner_low = ~|(req & grant_q);

  // Half-period length for the latched rate, and the winning requester
  always_comb begin
    half_sel = 8'(HALF0);
    case (cur_rate_q)
      2'd0: half_sel = 8'(HALF0);
      2'd1: half_sel = 8'(HALF1);
      2'd2: half_sel = 8'(HALF2);
      2'd3: half_sel = 8'(HALF3);
      default: half_sel = 8'(HALF0);
    endcase
    top_oh   = 3'b000;
    top_rate = 2'd0;
    if (req[2]) begin
      top_oh = 3'b100; top_rate = rate[5:4];
    end else if (req[1]) begin
      top_oh = 3'b010; top_rate = rate[3:2];
    end else if (req[0]) begin
      top_oh = 3'b001; top_rate = rate[1:0];
    end
    // any request strictly above the current owner
    higher = grant_q[0] ? |req[2:1] : (grant_q[1] ? req[2] : 1'b0);
  end

  // Arbitration decision: new grant (from IDLE or re-grant) or release
  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
    if (state_q == IDLE) begin
      do_grant = |req;
    end else begin
      if (hold_done && (owner_low || higher)) begin
        if (|req) do_grant = 1'b1;
        else      go_idle  = 1'b1;
      end
`ifdef LED_BLINK_SCHED_PREEMPT_EN
      if (higher) do_grant = 1'b1;
`endif
    end
  end

  // Next-state: prescaler, blink phase, period count, then arbitration override
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    ph_cnt_d   = ph_cnt_q;
    phase_d    = phase_q;
    per_d      = per_q;
    grant_d    = grant_q;
    cur_rate_d = cur_rate_q;
    if (en) pre_d = tick ? 16'd0 : pre_q + 16'd1;
    if (state_q == ACTIVE && tick) begin
      if (ph_cnt_q == half_sel - 8'd1) begin
        ph_cnt_d = 8'd0;
        phase_d  = ~phase_q;
        // a 0->1 edge closes one full period
        if (!phase_q && !hold_done) per_d = per_q + 4'd1;
      end else begin
        ph_cnt_d = ph_cnt_q + 8'd1;
      end
    end
    if (do_grant) begin
      state_d    = ACTIVE;
      grant_d    = top_oh;
      cur_rate_d = top_rate;
      pre_d      = 16'd0;
      ph_cnt_d   = 8'd0;
      per_d      = 4'd0;
      phase_d    = 1'b1;
    end else if (go_idle) begin
      state_d = IDLE;
      grant_d = 3'b000;
    end
    led_d  = phase_d && en && (state_d == ACTIVE);
    busy_d = (state_d == ACTIVE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      ph_cnt_q   <= '0;
      phase_q    <= 1'b0;
      per_q      <= '0;
      grant_q    <= '0;
      cur_rate_q <= '0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      ph_cnt_q   <= ph_cnt_d;
      phase_q    <= phase_d;
      per_q      <= per_d;
      grant_q    <= grant_d;
      cur_rate_q <= cur_rate_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign cur_rate = cur_rate_q;
  assign led      = led_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Self-checking bench for led_blink_sched with a tick-count reference model.
module tb_led_blink_sched;
  localparam int P   = 2;
  localparam int MIN = 2;

  logic       clk, rst_n, en;
  logic [2:0] req;
  logic [5:0] rate;
  logic [2:0] grant;
  logic [1:0] cur_rate;
  logic       led, busy;

  int npass = 0, ntotal = 0;

  led_blink_sched #(.PRESCALE(P), .HALF0(1), .HALF1(2), .HALF2(3), .HALF3(4),
                    .MIN_PERIODS(MIN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .rate(rate),
    .grant(grant), .cur_rate(cur_rate), .led(led), .busy(busy));

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: owner, latched rate, and enabled clocks since grant.
  // Blink state follows from ticks = ecyc/P: phase high in even half-periods,
  // completed periods = ticks / (2*half).
  bit   m_busy;
  int   m_g, m_rate, m_ecyc;
  logic [2:0] e_grant;
  logic [1:0] e_rate;
  logic       e_led, e_busy;

  function automatic int half_of(int r);
    return r + 1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_rate = 0; m_ecyc = 0;
  endtask

  task automatic cyc();
    logic [2:0] rq;
    logic [5:0] rt;
    logic       e;
    int t, hi;
    bit hold, higher, gr, idle;
    rq = req; rt = rate; e = en;
    @(posedge clk);
    t    = m_ecyc / P;
    hold = m_busy && ((t / (2 * half_of(m_rate))) >= MIN);
    hi   = rq[2] ? 2 : (rq[1] ? 1 : 0);
    gr = 0; idle = 0;
    if (!m_busy) gr = (rq != 0);
    else begin
      higher = (int'(rq) >> (m_g + 1)) != 0;
      if (hold && (!rq[m_g] || higher)) begin
        if (rq != 0) gr = 1; else idle = 1;
      end
`ifdef LED_BLINK_SCHED_PREEMPT_EN
      if (higher) gr = 1;
`endif
    end
    if (gr) begin
      m_busy = 1; m_g = hi; m_rate = (int'(rt) >> (2 * hi)) & 3; m_ecyc = 0;
    end else if (idle) m_busy = 0;
    else if (m_busy && e) m_ecyc++;
    e_busy  = m_busy;
    e_grant = m_busy ? 3'(1 << m_g) : 3'b000;
    e_rate  = 2'(m_rate);
    e_led   = m_busy && e && (((m_ecyc / P) / half_of(m_rate)) % 2 == 0);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req = 0; en = 1;
    #7;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    ntotal++;
    if ({grant, cur_rate, led, busy} !== 7'b0) $display("FAIL reset_outputs got=%b want=0", {grant, cur_rate, led, busy});
    else npass++;
    @(negedge clk); rst_n = 1; model_reset();
    cyc();
    ntotal++;
    if ({grant, busy} !== 4'b0) $display("FAIL reset_idle got=%b want=0", {grant, busy});
    else npass++;
  endtask

  task automatic test_single();
    logic exp_led;
    do_reset();
    rate = 6'b000001; req = 3'b001; en = 1;
    cyc();
    ntotal++;
    if (grant !== 3'b001 || led !== 1'b1 || busy !== 1'b1)
      $display("FAIL single_grant got=%b/%b want=001/1", grant, led);
    else npass++;
    for (int k = 1; k <= 18; k++) begin
      if (k == 5) req = 3'b000;
      cyc();
      exp_led = (k < 17) && ((k / 4) % 2 == 0);
      ntotal++;
      if (grant !== ((k < 17) ? 3'b001 : 3'b000) || led !== exp_led)
        $display("FAIL single_k%0d got=%b/%b want=%b/%b", k, grant, led, (k < 17) ? 3'b001 : 3'b000, exp_led);
      else npass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] r0;
    do_reset();
    r0 = 6'($urandom); rate = r0; req = 3'b111;
    cyc();
    ntotal++;
    if (grant !== 3'b100 || cur_rate !== r0[5:4])
      $display("FAIL simul_grant got=%b/%0d want=100/%0d", grant, cur_rate, r0[5:4]);
    else npass++;
    for (int k = 0; k < 4; k++) begin
      rate = ~rate;
      cyc();
      ntotal++;
      if (cur_rate !== r0[5:4] || grant !== 3'b100)
        $display("FAIL simul_rate_hold got=%b/%0d want=100/%0d", grant, cur_rate, r0[5:4]);
      else npass++;
    end
  endtask

  task automatic test_preempt();
    logic [2:0] eg;
    do_reset();
    rate = 6'b000001; req = 3'b001;
    cyc(); cyc(); cyc();
    req = 3'b101;
    for (int k = 3; k <= 19; k++) begin
      cyc();
`ifdef LED_BLINK_SCHED_PREEMPT_EN
      eg = 3'b100;
      if (k == 3) begin
        ntotal++;
        if (led !== 1'b1) $display("FAIL preempt_led got=%b want=1", led);
        else npass++;
      end
`else
      eg = (k < 17) ? 3'b001 : 3'b100;
`endif
      ntotal++;
      if (grant !== eg) $display("FAIL preempt_k%0d got=%b want=%b", k, grant, eg);
      else npass++;
      ntotal++;
      if ({grant, cur_rate, led, busy} !== {e_grant, e_rate, e_led, e_busy})
        $display("FAIL preempt_model_k%0d got=%b want=%b", k, {grant, cur_rate, led, busy}, {e_grant, e_rate, e_led, e_busy});
      else npass++;
    end
  endtask

  task automatic test_enable();
    do_reset();
    rate = 6'b001000; req = 3'b010;
    for (int k = 0; k < 26; k++) begin
      en = !(k >= 5 && k < 13);
      cyc();
      if (!en) begin
        ntotal++;
        if (led !== 1'b0) $display("FAIL enable_led_off got=%b want=0", led);
        else npass++;
      end
      ntotal++;
      if ({grant, cur_rate, led, busy} !== {e_grant, e_rate, e_led, e_busy})
        $display("FAIL enable_k%0d got=%b want=%b", k, {grant, cur_rate, led, busy}, {e_grant, e_rate, e_led, e_busy});
      else npass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k % 7 == 0) req = 3'($urandom) & 3'($urandom);
      rate = 6'($urandom);
      en = ($urandom % 8) != 0;
      cyc();
      ntotal++;
      if ({grant, cur_rate, led, busy} !== {e_grant, e_rate, e_led, e_busy})
        $display("FAIL random_k%0d got=%b want=%b", k, {grant, cur_rate, led, busy}, {e_grant, e_rate, e_led, e_busy});
      else npass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b100; rate = 6'b110000;
    cyc(); cyc(); cyc();
    #2 rst_n = 0;
    #1;
    ntotal++;
    if ({grant, cur_rate, led, busy} !== 7'b0)
      $display("FAIL reset_async got=%b want=0", {grant, cur_rate, led, busy});
    else npass++;
    @(negedge clk); @(negedge clk);
    req = 3'b000; rst_n = 1; model_reset();
    cyc();
    ntotal++;
    if ({grant, led, busy} !== 5'b0) $display("FAIL reset_release got=%b want=0", {grant, led, busy});
    else npass++;
  endtask

  initial begin
    rst_n = 0; en = 0; req = 0; rate = 0;
    model_reset();
    #12;
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_enable();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
